s_box: RTL and testbench

S_BOX -- requirements
Module: S_box

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/sbox_lut.sv | 12 +
 rtl/s_box.sv | 28 ++
 tb/tb_s_box.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: forward and inverse S-box tables plus lookup helpers.
// The inverse table and helper are held here for the decryption path.
package aes_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[x];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[x];
  endfunction

endpackage

// File: rtl/sbox_lut.sv
// Unregistered forward S-box lookup; also usable directly by SubBytes and
// key-expansion datapaths.
module sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_fwd(i_byte);

endmodule

// File: rtl/s_box.sv
// Registered AES forward S-box: one-cycle latency, synchronous active-high reset.
module s_box (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [7:0] out
);

  logic [7:0] w_sub;
  logic [7:0] r_out;

  sbox_lut u_lut (
    .i_byte (in),
    .o_byte (w_sub)
  );

  // Output register; reset drops any pending substitution
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 8'h00;
    end else begin
      r_out <= w_sub;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_s_box.sv
// Bench for s_box: directed table, latency/reset/hold sequences, exhaustive
// sweep and random stream, checked against a GF(2^8) inverse + affine model.
module tb_s_box;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_tbl [256];

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t vecs [12];

  s_box dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] y;
    if (x == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      y = c[7:0];
      if (gmul(x, y) == 8'h01) return y;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: out=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen [256];
    int distinct;
    logic r_rand;
    logic [7:0] d_rand;

    rst = 1'b1;
    din = 8'h23;

    for (int i = 0; i < 256; i++) ref_tbl[i] = model_sbox(i[7:0]);

    // Reset with in=0x23, release, then directed vectors
    vecs[0]  = '{1'b1, 8'h23, 8'h00};
    vecs[1]  = '{1'b1, 8'h23, 8'h00};
    vecs[2]  = '{1'b0, 8'h23, 8'h26};
    vecs[3]  = '{1'b0, 8'h00, 8'h63};
    vecs[4]  = '{1'b0, 8'h56, 8'hb1};
    vecs[5]  = '{1'b0, 8'ha3, 8'h0a};
    vecs[6]  = '{1'b0, 8'h4e, 8'h2f};
    vecs[7]  = '{1'b0, 8'h19, 8'hd4};
    vecs[8]  = '{1'b0, 8'hff, 8'h16};
    vecs[9]  = '{1'b0, 8'hcc, 8'h4b};
    vecs[10] = '{1'b0, 8'hdf, 8'h9e};
    vecs[11] = '{1'b1, 8'hdf, 8'h00};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d_in%02h", i, vecs[i].d), dout, vecs[i].e);
    end

    // Latency: input change between edges must not reach out early
    step(1'b0, 8'h00);
    check("lat_first", dout, 8'h63);
    #3 din = 8'h19;
    #2 check("lat_midcycle", dout, 8'h63);
    @(posedge clk);
    #1 check("lat_next_edge", dout, 8'hd4);

    // Mid-stream reset; rst raised between edges has no immediate effect
    step(1'b0, 8'h56);
    check("mid_0x56", dout, 8'hb1);
    rst = 1'b1;
    din = 8'ha3;
    #2 check("mid_rst_async", dout, 8'hb1);
    @(posedge clk);
    #1 check("mid_rst_edge", dout, 8'h00);
    step(1'b0, 8'hcc);
    check("mid_release", dout, 8'h4b);

    // Hold 0xFF for five cycles, also probing between edges
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'hff);
      check($sformatf("hold%0d", i), dout, 8'h16);
      #3 check($sformatf("hold%0d_mid", i), dout, 8'h16);
    end

    // Exhaustive sweep on consecutive cycles
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, i[7:0]);
      check($sformatf("sweep_%02h", i), dout, ref_tbl[i]);
      if (!$isunknown(dout)) seen[dout] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    n_checks++;
    if (distinct != 256) begin
      n_errors++;
      $display("FAIL bijection: distinct=%0d expected=256", distinct);
    end

    // Random stream with occasional reset
    for (int i = 0; i < 300; i++) begin
      r_rand = ($urandom_range(0, 15) == 0);
      d_rand = 8'($urandom_range(0, 255));
      step(r_rand, d_rand);
      check($sformatf("rand%0d_in%02h_r%0d", i, d_rand, r_rand), dout,
            r_rand ? 8'h00 : ref_tbl[d_rand]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
